// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, round constants, initial hash value and the
// bitwise helper functions used by the compression engine.
package sha256_pkg;

  typedef logic [31:0] word_t;

  // Working variables a..h; a sits in the top word so the packing matches
  // in_chain/out_digest directly.
  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
    word_t e;
    word_t f;
    word_t g;
    word_t h;
  } work_t;

  // 16-word message schedule window; index 0 is the oldest word.
  typedef logic [15:0][31:0] win_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic word_t bsig0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t bsig1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ssig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Word-wise modular sum of two chaining values (final feed-forward).
  function automatic work_t add_state(input work_t x, input work_t y);
    work_t r;
    r.a = x.a + y.a;
    r.b = x.b + y.b;
    r.c = x.c + y.c;
    r.d = x.d + y.d;
    r.e = x.e + y.e;
    r.f = x.f + y.f;
    r.g = x.g + y.g;
    r.h = x.h + y.h;
    return r;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: (a..h, Wt, Kt) -> (a'..h').
module sha256_round
  import sha256_pkg::*;
(
  input  work_t cur,
  input  word_t wt,
  input  word_t kt,
  output work_t nxt
);

  word_t t1;
  word_t t2;

  // Compute T1/T2 and shift the working variables down by one slot
  always_comb begin
    t1    = cur.h + bsig1(cur.e) + ch(cur.e, cur.f, cur.g) + kt + wt;
    t2    = bsig0(cur.a) + maj(cur.a, cur.b, cur.c);
    nxt.a = t1 + t2;
    nxt.b = cur.a;
    nxt.c = cur.b;
    nxt.d = cur.c;
    nxt.e = cur.d + t1;
    nxt.f = cur.e;
    nxt.g = cur.f;
    nxt.h = cur.g;
  end

endmodule

// File: rtl/sha256_compress_iter.sv
// Iterative SHA-256 compression: one 512-bit block + 256-bit chaining value
// in, updated chaining value out, UNROLL rounds per clock.
module sha256_compress_iter
  import sha256_pkg::*;
#(
  parameter int UNROLL = 1,
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic [255:0] in_chain,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest,
  output logic         busy
);

  localparam int TW = $clog2(ROUNDS);
  localparam logic [TW-1:0] LAST_T = TW'(ROUNDS - UNROLL);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
    $error("sha256_compress_iter: UNROLL must be 1, 2, 4 or 8");
  end
  if (ROUNDS != 64 || (ROUNDS % UNROLL) != 0) begin : g_bad_rounds
    $error("sha256_compress_iter: ROUNDS must be 64 and a multiple of UNROLL");
  end

  state_e        state_q, state_d;
  work_t         work_q;
  work_t         hsave_q;
  win_t          win_q;
  logic [TW-1:0] t_q;
  logic          out_valid_q;
  logic [255:0]  digest_q;
  logic          accept;

  // Per-stage values along the unrolled round chain
  work_t st [0:UNROLL];
  win_t  wc [0:UNROLL];
  word_t wt [0:UNROLL-1];
  word_t kt [0:UNROLL-1];

  assign in_ready   = rst_n && (state_q == S_IDLE);
  assign accept     = in_valid && in_ready;
  assign busy       = (state_q == S_RUN) || (state_q == S_FINAL);
  assign out_valid  = out_valid_q;
  assign out_digest = digest_q;
  assign st[0]      = work_q;

  // Message schedule: pick or expand Wt per round and slide the window.
  // Before round 16 the window rotates its own words, so after 16 rounds it
  // holds W[t-16]..W[t-1] exactly as the expansion needs.
  always_comb begin
    // NOTE: every combinational output gets a value on every path; a missing
    // default here would infer a latch.
    wc[0] = win_q;
    for (int u = 0; u < UNROLL; u++) begin
      if ((t_q + TW'(u)) < TW'(16)) begin
        wt[u] = wc[u][0];
      end else begin
        wt[u] = ssig1(wc[u][14]) + wc[u][9] + ssig0(wc[u][1]) + wc[u][0];
      end
      kt[u]    = K[t_q + TW'(u)];
      wc[u+1]  = {wt[u], wc[u][15:1]};
    end
  end

  for (genvar u = 0; u < UNROLL; u++) begin : g_round
    sha256_round u_round (
      .cur (st[u]),
      .wt  (wt[u]),
      .kt  (kt[u]),
      .nxt (st[u+1])
    );
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept)         state_d = S_RUN;
      S_RUN:   if (t_q == LAST_T)  state_d = S_FINAL;
      S_FINAL:                     state_d = S_DONE;
      S_DONE:  if (out_ready)      state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  // Datapath: load, iterate rounds, feed forward, hold result for handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the schedule window is a flop array, not a RAM, so it is reset
      // along with everything else to leave no trace of an aborted block.
      work_q      <= '0;
      hsave_q     <= '0;
      win_q       <= '0;
      t_q         <= '0;
      out_valid_q <= 1'b0;
      digest_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            work_q  <= work_t'(in_chain);
            hsave_q <= work_t'(in_chain);
            for (int i = 0; i < 16; i++) begin
              win_q[i] <= in_block[511 - 32*i -: 32];
            end
            t_q <= '0;
          end
        end
        S_RUN: begin
          work_q <= st[UNROLL];
          win_q  <= wc[UNROLL];
          t_q    <= t_q + TW'(UNROLL);
        end
        S_FINAL: begin
          digest_q    <= add_state(hsave_q, work_q);
          out_valid_q <= 1'b1;
        end
        S_DONE: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_compress_iter.sv
// Directed bench for sha256_compress_iter: known-answer digests at every
// legal UNROLL, latency, back-pressure and mid-block reset.
module tb_sha256_compress_iter;

  localparam logic [255:0] IV      = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMP_BLK = {32'h80000000, 480'h0};
  localparam logic [511:0] TWO_B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] TWO_B2  = {448'h0, 64'h1c0};
  localparam logic [255:0] ABC_D   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMP_D   = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] MID_D   = 256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;
  localparam logic [255:0] TWO_D   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [3:0]   busy;
  logic [511:0] in_block;
  logic [255:0] in_chain;
  logic [255:0] out_digest [0:3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance g runs with UNROLL = 1, 2, 4, 8
  for (genvar g = 0; g < 4; g++) begin : g_dut
    sha256_compress_iter #(.UNROLL(1 << g), .ROUNDS(64)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_block   (in_block),
      .in_chain   (in_chain),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready[g]),
      .out_digest (out_digest[g]),
      .busy       (busy[g])
    );
  end

  typedef struct {
    string        name;
    int           k;
    logic [511:0] blk;
    logic [255:0] chain;
    logic [255:0] exp;
  } vec_t;

  vec_t vecs [0:11];

  function automatic vec_t mk(input string name, input int k, input logic [511:0] blk,
                              input logic [255:0] chain, input logic [255:0] exp);
    vec_t v;
    v.name  = name;
    v.k     = k;
    v.blk   = blk;
    v.chain = chain;
    v.exp   = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one block to instance k, measure latency, check digest and release
  task automatic run_vec(input string name, input int k, input logic [511:0] blk,
                         input logic [255:0] chain, input logic [255:0] exp);
    int n;
    int lat;
    lat = (64 >> k) + 1;
    @(negedge clk);
    check($sformatf("%s ready", name), 256'(in_ready[k]), 256'(1));
    in_block    = blk;
    in_chain    = chain;
    in_valid[k] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    n = 0;
    while (!out_valid[k] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("%s latency", name), 256'(n), 256'(lat));
    check($sformatf("%s digest", name), out_digest[k], exp);
    check($sformatf("%s ready low in done", name), 256'(in_ready[k]), 256'(0));
    @(negedge clk);
    out_ready[k] = 1'b1;
    @(posedge clk);
    #1;
    check($sformatf("%s valid drop", name), 256'(out_valid[k]), 256'(0));
    check($sformatf("%s ready back", name), 256'(in_ready[k]), 256'(1));
    out_ready[k] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = '0;
    out_ready = '0;
    in_block  = '0;
    in_chain  = '0;

    vecs[0]  = mk("abc u1",   0, ABC_BLK, IV,    ABC_D);
    vecs[1]  = mk("abc u2",   1, ABC_BLK, IV,    ABC_D);
    vecs[2]  = mk("abc u4",   2, ABC_BLK, IV,    ABC_D);
    vecs[3]  = mk("abc u8",   3, ABC_BLK, IV,    ABC_D);
    vecs[4]  = mk("empty u1", 0, EMP_BLK, IV,    EMP_D);
    vecs[5]  = mk("empty u2", 1, EMP_BLK, IV,    EMP_D);
    vecs[6]  = mk("empty u4", 2, EMP_BLK, IV,    EMP_D);
    vecs[7]  = mk("empty u8", 3, EMP_BLK, IV,    EMP_D);
    vecs[8]  = mk("two b1 u1", 0, TWO_B1, IV,    MID_D);
    vecs[9]  = mk("two b2 u1", 0, TWO_B2, MID_D, TWO_D);
    vecs[10] = mk("two b1 u8", 3, TWO_B1, IV,    MID_D);
    vecs[11] = mk("two b2 u8", 3, TWO_B2, MID_D, TWO_D);

    // Reset state
    #12;
    check("reset in_ready", 256'(in_ready), 256'(0));
    check("reset out_valid", 256'(out_valid), 256'(0));
    check("reset busy", 256'(busy), 256'(0));
    for (int g = 0; g < 4; g++) check($sformatf("reset digest %0d", g), out_digest[g], 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-reset in_ready", 256'(in_ready), 256'(4'hf));

    // Known-answer table
    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i].name, vecs[i].k, vecs[i].blk, vecs[i].chain, vecs[i].exp);
    end

    // Back-pressure: hold out_ready low, offer a competing block meanwhile
    @(negedge clk);
    in_block    = ABC_BLK;
    in_chain    = IV;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    n = 0;
    while (!out_valid[0] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("bp latency", 256'(n), 256'(65));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_block    = EMP_BLK;
      in_valid[0] = 1'b1;
      check($sformatf("bp valid held %0d", c), 256'(out_valid[0]), 256'(1));
      check($sformatf("bp digest stable %0d", c), out_digest[0], ABC_D);
      check($sformatf("bp ready low %0d", c), 256'(in_ready[0]), 256'(0));
    end
    @(negedge clk);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    check("bp release valid drop", 256'(out_valid[0]), 256'(0));
    check("bp release ready", 256'(in_ready[0]), 256'(1));
    out_ready[0] = 1'b0;
    @(posedge clk);
    #1;
    check("bp no stale accept", 256'(busy[0]), 256'(0));

    // Asynchronous reset at round 30 of an in-flight block
    @(negedge clk);
    in_block    = ABC_BLK;
    in_chain    = IV;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    check("mid busy before reset", 256'(busy[0]), 256'(1));
    rst_n = 1'b0;
    #1;
    check("mid reset out_valid", 256'(out_valid), 256'(0));
    check("mid reset digest", out_digest[0], 256'(0));
    check("mid reset in_ready", 256'(in_ready), 256'(0));
    check("mid reset busy", 256'(busy), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("no spurious valid", 256'(out_valid), 256'(0));
    end
    run_vec("abc after reset", 0, ABC_BLK, IV, ABC_D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_compress_iter.md
Name: sha256_compress_iter

Overview:
- Iterative SHA-256 compression engine: takes one 512-bit message block plus a 256-bit chaining value and returns the updated 256-bit chaining value.
- Successor to the combinational Ch/Maj/Σ0/Σ1 helpers: adds the message schedule, the K constants, a round counter, valid/ready handshakes and a parametrised number of rounds per clock.
- Sits between a padding/block-feeder front end and a digest collector; multi-block messages are chained by feeding out_digest back as in_chain.

Parameters:
- UNROLL, 1: rounds computed per clock. Legal values 1, 2, 4, 8; any other value is an elaboration error.
- ROUNDS, 64: total rounds. Fixed for SHA-256; must be a multiple of UNROLL.

Ports:
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  in_block/in_chain valid
- in_ready  output  1  engine can accept a block
- in_block  input  512  message block; [511:480] = W0 … [31:0] = W15
- in_chain  input  256  H0..H7; [255:224] = H0 (a) … [31:0] = H7 (h)
- out_valid  output  1  out_digest valid
- out_ready  input  1  downstream accepts digest
- out_digest  output  256  updated chaining value, same packing as in_chain
- busy  output  1  high in RUN or FINAL

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, out_valid=0, out_digest=0, round counter=0, working regs a..h=0, schedule window=0. in_ready=0 while rst_n=0, then 1.
- FSM IDLE -> RUN -> FINAL -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load a..h from in_chain, copy in_chain into a saved H register, load the 16-word window from in_block, clear counter t, go to RUN.
- RUN:
  - Each edge applies UNROLL consecutive rounds t..t+UNROLL-1 in a combinational chain.
  - Round t uses Wt = window[0] when t<16, otherwise σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16].
  - The window shifts one word per round, with the new Wt appended.
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + Wt; T2 = Σ0(a) + Maj(a,b,c).
  - Update: h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2.
  - All additions are mod 2^32; carries are discarded.
  - t advances by UNROLL. After the edge that completes round 63, go to FINAL.
- FINAL: one edge; out_digest[i] = saved H[i] + working var[i] mod 2^32; out_valid←1; go to DONE.
- DONE:
  - out_valid held and out_digest stable until out_ready=1.
  - On out_valid&out_ready: out_valid←0 and go to IDLE. The next block can be accepted one cycle later.
- Latency: accept edge to out_valid=1 takes 64/UNROLL + 1 edges (UNROLL=1: 65; UNROLL=8: 9).
- Throughput: one block per 64/UNROLL + 3 cycles when out_ready is held high.
- in_ready=0 in RUN, FINAL and DONE. in_valid and in_block are ignored there, and an upstream driver must hold them.
- out_ready asserted while out_valid=0 has no effect.
- Reset mid-operation: the block in flight is discarded; all registers return to reset values; no spurious out_valid.
- No back-to-back overlap; in_ready is never combinationally dependent on out_ready.

Decomposition:
- Package sha256_pkg holds:
  - K[0:63] constant table
  - IV constant (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19)
  - functions Ch, Maj, Σ0 (rotr 2/13/22), Σ1 (rotr 6/11/25), σ0 (rotr 7, rotr 18, shr 3), σ1 (rotr 17, rotr 19, shr 10)
  - state encoding constants
- One sub-module, sha256_round: purely combinational single round taking (a..h, Wt, Kt) to (a'..h'). It is instantiated UNROLL times in a chain. Schedule expansion stays in the top module.

Test Plan:
- "abc": in_block = 61626380, fourteen 00000000 words, 00000018; in_chain = IV -> out_digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, out_valid rising 65 edges after accept (UNROLL=1).
- Empty message: in_block = 80000000 followed by zeros; in_chain = IV -> out_digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": second block chained from first out_digest -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Back-pressure: hold out_ready=0 for 20 cycles after out_valid -> out_digest stable, in_ready=0, a new in_valid is not accepted; release -> out_valid drops the next edge and in_ready returns.
- Reset at round 30: pull rst_n low asynchronously -> out_valid=0, out_digest=0, in_ready=0 immediately; after release, the "abc" block gives the correct digest.
- Repeat the "abc" and empty-message vectors with UNROLL=2,4,8 -> identical digests with latency 33, 17 and 9 edges.
